ptmch_reg: RTL and testbench

PTMCH_REG -- requirements
Module: ptmch_reg

---
 rtl/ptmch_reg_if.sv | 19 +
 rtl/ptmch_reg.sv | 143 ++++++++++++++
 tb/tb_ptmch_reg.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ptmch_reg_if.sv
// Avalon-MM slave bus for the trigger-counter snapshot register block.
interface ptmch_reg_if;
  logic [3:0]  AVS_ADDRESS;
  logic        AVS_READ;
  logic        AVS_WRITE;
  logic [31:0] AVS_WRITEDATA;
  logic [31:0] AVS_READDATA;
  logic        AVS_READDATAVALID;

  modport slave (
    input  AVS_ADDRESS, AVS_READ, AVS_WRITE, AVS_WRITEDATA,
    output AVS_READDATA, AVS_READDATAVALID
  );

  modport master (
    output AVS_ADDRESS, AVS_READ, AVS_WRITE, AVS_WRITEDATA,
    input  AVS_READDATA, AVS_READDATAVALID
  );
endinterface

// File: rtl/ptmch_reg.sv
// Snapshot register block: shadows five live trigger counters plus a cycle
// timestamp on manual or periodic triggers, and requests upstream clears.
module ptmch_reg #(
  parameter int unsigned SNAP_PERIOD = 100_000_000
) (
  input  logic        CLK100M,
  input  logic        RESET,
  ptmch_reg_if.slave  avs,
  input  logic [31:0] PRGEXCT,
  input  logic [31:0] RDSTAT,
  input  logic [31:0] BLKERS,
  input  logic [31:0] PDREAD,
  input  logic [31:0] WRSTAT,
  output logic        CNT_CLR,
  output logic        SNAP_IRQ
);

  localparam logic [31:0] PLAST = 32'(SNAP_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SNAP, CLR} state_t;

  state_t          state;
  logic [4:0][31:0] live, shadow;
  logic [4:0]      sat;
  logic [31:0]     ts, ts_sh, pcnt, rmux;
  logic [7:0]      seq;
  logic            auto_en, snap_pend, clr_pend, clr_q, irq;
  logic            ctrl_wr, stat_wr, snap_w, clr_w, auto_trig, trig, clr_req, load;
  logic            unused;

  assign live = {WRSTAT, PDREAD, BLKERS, RDSTAT, PRGEXCT};

  assign ctrl_wr   = avs.AVS_WRITE && avs.AVS_ADDRESS == 4'h0;
  assign stat_wr   = avs.AVS_WRITE && avs.AVS_ADDRESS == 4'h1;
  assign snap_w    = ctrl_wr && avs.AVS_WRITEDATA[0];
  assign clr_w     = ctrl_wr && avs.AVS_WRITEDATA[1];
  assign auto_trig = auto_en && pcnt == PLAST;
  // A pending trigger merges with any new one, so coincident triggers give one snapshot.
  assign trig      = snap_w || auto_trig || snap_pend;
  assign clr_req   = clr_w || clr_pend;
  assign load      = state == IDLE && trig;

  // The clear request is held low by RESET so an aborted clear never reaches upstream.
  assign CNT_CLR  = clr_q && !RESET;
  assign SNAP_IRQ = irq;
  assign unused   = ^{avs.AVS_WRITEDATA[31:17], avs.AVS_WRITEDATA[15:3]};

  // Live saturation flags, one per counter.
  always_comb begin
    sat = '0;
    for (int i = 0; i < 5; i++) sat[i] = &live[i];
  end

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge CLK100M) begin
    if (RESET) ts <= '0;
    else       ts <= ts + 32'd1;
  end

  // AUTO enable and period counter; restarts on enable, holds at 0 while disabled.
  always_ff @(posedge CLK100M) begin
    if (RESET) begin
      auto_en <= 1'b0;
      pcnt    <= '0;
    end else begin
      if (ctrl_wr) auto_en <= avs.AVS_WRITEDATA[2];
      if (!auto_en || auto_trig || (ctrl_wr && !avs.AVS_WRITEDATA[2])) pcnt <= '0;
      else                                                             pcnt <= pcnt + 32'd1;
    end
  end

  // Shadow capture, sequence number and interrupt; a snapshot beats a same-cycle clear.
  always_ff @(posedge CLK100M) begin
    if (RESET) begin
      shadow <= '0;
      ts_sh  <= '0;
      seq    <= '0;
      irq    <= 1'b0;
    end else if (load) begin
      shadow <= live;
      ts_sh  <= ts;
      seq    <= seq + 8'd1;
      irq    <= 1'b1;
    end else if (stat_wr && avs.AVS_WRITEDATA[16]) begin
      irq    <= 1'b0;
    end
  end

  // Control FSM. A combined SNAP+CLR loads on the IDLE exit edge and goes
  // straight to CLR so the clear pulse still lands the cycle after the write.
  always_ff @(posedge CLK100M) begin
    if (RESET) begin
      state     <= IDLE;
      snap_pend <= 1'b0;
      clr_pend  <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          snap_pend <= 1'b0;
          clr_pend  <= 1'b0;
          clr_q     <= clr_req;
          if (clr_req)   state <= CLR;
          else if (trig) state <= SNAP;
        end
        default: begin
          state <= IDLE;
          clr_q <= 1'b0;
          if (snap_w || auto_trig) snap_pend <= 1'b1;
          if (clr_w)               clr_pend  <= 1'b1;
        end
      endcase
    end
  end

  // Read mux sees register state before any same-cycle write.
  always_comb begin
    rmux = '0;
    case (avs.AVS_ADDRESS)
      4'h0: rmux = {31'b0, auto_en};
      4'h1: rmux = {15'b0, irq, seq, 3'b0, sat};
      4'h2: rmux = shadow[0];
      4'h3: rmux = shadow[1];
      4'h4: rmux = shadow[2];
      4'h5: rmux = shadow[3];
      4'h6: rmux = shadow[4];
      4'h7: rmux = ts_sh;
      default: rmux = '0;
    endcase
  end

  // One-cycle read response; data holds between reads.
  always_ff @(posedge CLK100M) begin
    if (RESET) begin
      avs.AVS_READDATA      <= '0;
      avs.AVS_READDATAVALID <= 1'b0;
    end else begin
      avs.AVS_READDATAVALID <= avs.AVS_READ;
      if (avs.AVS_READ) avs.AVS_READDATA <= rmux;
    end
  end

endmodule

// File: tb/tb_ptmch_reg.sv
// Bench for ptmch_reg: read-back table, scoreboarded read responses and
// hand-timed sequences for clear pulse, pending trigger, auto period and reset abort.
module tb_ptmch_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ptmch_reg_if bus ();
  logic [31:0] prg, rds, blk, pdr, wrs;
  logic        cnt_clr, irq;

  ptmch_reg #(.SNAP_PERIOD(10)) dut (
    .CLK100M(clk), .RESET(rst), .avs(bus),
    .PRGEXCT(prg), .RDSTAT(rds), .BLKERS(blk), .PDREAD(pdr), .WRSTAT(wrs),
    .CNT_CLR(cnt_clr), .SNAP_IRQ(irq)
  );

  typedef struct { logic [3:0] addr; logic [31:0] exp; } vec_t;
  vec_t tbl [10] = '{
    '{4'h0, 32'h0000_0000}, '{4'h1, 32'h0001_0104}, '{4'h2, 32'h0000_0005},
    '{4'h3, 32'h0000_0011}, '{4'h4, 32'hFFFF_FFFF}, '{4'h5, 32'h0000_0022},
    '{4'h6, 32'h0000_0009}, '{4'h7, 32'h0000_0000}, '{4'hA, 32'h0000_0000},
    '{4'hF, 32'h0000_0000}
  };

  int          n_vec = 0, n_err = 0;
  logic [31:0] exp_q [$];
  logic        rd_d = 1'b0;
  logic [31:0] ts_m = '0;
  logic [31:0] t_snap, tw;

  // Reference timestamp and expected read-valid timing.
  always @(posedge clk) begin
    rd_d <= rst ? 1'b0 : bus.AVS_READ;
    ts_m <= rst ? 32'd0 : ts_m + 32'd1;
  end

  function automatic logic [31:0] stat(input logic i, input logic [7:0] s, input logic [4:0] f);
    return {15'b0, i, s, 3'b0, f};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Read scoreboard: valid must trail each read by one cycle, data pops in order.
  always @(negedge clk) begin
    if (rd_d || bus.AVS_READDATAVALID) begin
      if (bus.AVS_READDATAVALID !== rd_d) chk("rvalid", 32'(bus.AVS_READDATAVALID), 32'(rd_d));
      else if (exp_q.size() == 0)         chk("rvalid_unexpected", 32'd1, 32'd0);
      else                                chk("rdata", bus.AVS_READDATA, exp_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    bus.AVS_READ  = 1'b0;
    bus.AVS_WRITE = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cyc();
    bus.AVS_ADDRESS = a; bus.AVS_WRITEDATA = d; bus.AVS_WRITE = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    cyc();
    bus.AVS_ADDRESS = a; bus.AVS_READ = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
    cyc();
    bus.AVS_ADDRESS = a; bus.AVS_WRITEDATA = d; bus.AVS_READ = 1'b1; bus.AVS_WRITE = 1'b1;
    exp_q.push_back(e);
  endtask

  // Leaves the bench in cycle c-1 so the next operation lands in cycle c.
  task automatic idle_until(input logic [31:0] c);
    while (ts_m < c - 32'd1) cyc();
  endtask

  initial begin
    bus.AVS_ADDRESS = '0; bus.AVS_READ = 1'b0; bus.AVS_WRITE = 1'b0; bus.AVS_WRITEDATA = '0;
    prg = '0; rds = '0; blk = '0; pdr = '0; wrs = '0;

    // Reset state
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_rdata", bus.AVS_READDATA, 32'd0);
    chk("rst_rvalid", 32'(bus.AVS_READDATAVALID), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_cnt_clr", 32'(cnt_clr), 32'd0);
    cyc(); rst = 1'b0;

    // Manual snapshot, then read the whole map back after inputs move on
    prg = 32'd5; rds = 32'h11; blk = 32'hFFFF_FFFF; pdr = 32'h22; wrs = 32'd9;
    wr(4'h0, 32'h1); t_snap = ts_m;
    cyc(); prg = 32'h55; rds = 32'h66; pdr = 32'h77; wrs = 32'h88;
    tbl[7].exp = t_snap;
    for (int i = 0; i < 10; i++) rd(tbl[i].addr, tbl[i].exp);
    cyc(); cyc();

    // IRQ clear through STATUS
    wr(4'h1, 32'h0001_0000);
    @(negedge clk); chk("irq_before_clr", 32'(irq), 32'd1);
    cyc(); @(negedge clk); chk("irq_cleared", 32'(irq), 32'd0);
    rd(4'h1, stat(1'b0, 8'd1, 5'b00100));

    // Writes to read-only / unmapped space are ignored
    wr(4'h2, 32'hDEAD_0000); wr(4'hA, 32'hBEEF_0000);
    rd(4'h2, 32'd5); rd(4'hA, 32'd0); rd(4'hF, 32'd0);

    // SNAP+CLR: pre-clear capture and single-cycle CNT_CLR one cycle after the write
    rds = 32'd7;
    wr(4'h0, 32'h3);
    @(negedge clk); chk("cnt_clr_wcyc", 32'(cnt_clr), 32'd0);
    cyc(); rds = 32'd0;
    @(negedge clk); chk("cnt_clr_pulse", 32'(cnt_clr), 32'd1);
    cyc(); @(negedge clk); chk("cnt_clr_after1", 32'(cnt_clr), 32'd0);
    cyc(); @(negedge clk); chk("cnt_clr_after2", 32'(cnt_clr), 32'd0);
    rd(4'h3, 32'd7);
    rd(4'h1, stat(1'b1, 8'd2, 5'b00100));

    // Same-cycle read and IRQ clear: read sees pre-write state
    rdwr(4'h1, 32'h0001_0000, stat(1'b1, 8'd2, 5'b00100));
    rd(4'h1, stat(1'b0, 8'd2, 5'b00100));

    // Trigger during SNAP is held and serviced with the inputs of the service cycle
    wr(4'h0, 32'h1); prg = 32'hA;
    wr(4'h0, 32'h1); prg = 32'hB;
    cyc();           prg = 32'hC;
    cyc();           prg = 32'hD;
    rd(4'h2, 32'hC);
    rd(4'h1, stat(1'b1, 8'd4, 5'b00100));
    cyc(); cyc();

    // Reset the cycle after a CTRL=0x3 write aborts the clear
    wr(4'h0, 32'h3);
    cyc(); rst = 1'b1;
    @(negedge clk); chk("abort_cnt_clr", 32'(cnt_clr), 32'd0);
    cyc();
    @(negedge clk);
    chk("abort_rdata", bus.AVS_READDATA, 32'd0);
    chk("abort_rvalid", 32'(bus.AVS_READDATAVALID), 32'd0);
    chk("abort_irq", 32'(irq), 32'd0);
    chk("abort_cnt_clr2", 32'(cnt_clr), 32'd0);
    cyc(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk); chk("abort_no_pulse", 32'(cnt_clr), 32'd0);
    end

    // AUTO: first snapshot 10 cycles after enable, then every 10
    wr(4'h0, 32'h4); tw = ts_m;
    repeat (10) cyc();
    @(negedge clk); chk("auto_early", 32'(irq), 32'd0);
    cyc(); @(negedge clk); chk("auto_first", 32'(irq), 32'd1);
    idle_until(tw + 32'd15);
    wr(4'h1, 32'h0001_0000);
    cyc(); @(negedge clk); chk("auto_irq_clr", 32'(irq), 32'd0);
    idle_until(tw + 32'd20);
    wr(4'h1, 32'h0001_0000);
    rd(4'h1, stat(1'b1, 8'd2, 5'b00100));
    @(negedge clk); chk("irq_set_wins", 32'(irq), 32'd1);
    rd(4'h0, 32'd1);
    idle_until(tw + 32'd2555);
    rd(4'h1, stat(1'b1, 8'hFF, 5'b00100));
    idle_until(tw + 32'd2565);
    rd(4'h1, stat(1'b1, 8'h00, 5'b00100));
    rd(4'h7, tw + 32'd2560);
    wr(4'h0, 32'h0);
    repeat (20) cyc();
    rd(4'h1, stat(1'b1, 8'h00, 5'b00100));
    rd(4'h0, 32'd0);

    repeat (3) cyc();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
